// File: rtl/result_reader_if.sv
// result_reader_if: result-memory read port and serial output stream.
// Ports (master = reader side):
//    re, raddr                        read enable / address to result memory
//    rdata                            memory read data, valid the cycle after re
//    ser_out, ser_valid, ser_first    serial bit, bit accepted, first (MSB) bit of word
//    tx_ready                         downstream accepts a bit this cycle
interface result_reader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
);
   logic              re;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              ser_out;
   logic              ser_valid;
   logic              ser_first;
   logic              tx_ready;
   modport master (output re, raddr, ser_out, ser_valid, ser_first, input rdata, tx_ready);
   modport slave  (input re, raddr, ser_out, ser_valid, ser_first, output rdata, tx_ready);
endinterface

// File: rtl/result_reader.sv
// result_reader: reads N_WORDS result words from memory and streams them MSB first.
// Ports:
//    clk, rst     clock, synchronous active-high reset
//    start        level request; a run begins once start falls
//    bus          result_reader_if master: memory read port and serial stream
//    busy         high in every state except IDLE
//    done         one-cycle pulse after the last bit of the last word
module result_reader #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 3,
   parameter int N_WORDS = 8
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   result_reader_if.master bus,
   output logic            busy,
   output logic            done
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   typedef enum logic [2:0] {IDLE, ARM, READ, WAIT, SEND, NEXT, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic              re_q, busy_q, done_q;
   logic              fire, last_bit, last_word;
   assign fire      = state_q == SEND && bus.tx_ready;
   assign last_bit  = cnt_q == CNT_W'(DATA_W - 1);
   assign last_word = addr_q == ADDR_W'(N_WORDS - 1);
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? ARM : IDLE;
         ARM:     state_d = start ? ARM : READ;
         READ:    state_d = WAIT;
         WAIT:    state_d = SEND;
         SEND:    state_d = fire && last_bit ? NEXT : SEND;
         NEXT:    state_d = last_word ? DONE : READ;
         default: state_d = IDLE;
      endcase
   end
   // Status outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         shreg_q <= '0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         re_q    <= state_d == READ;
         busy_q  <= state_d != IDLE;
         done_q  <= state_d == DONE;
         if (state_q == ARM) addr_q <= '0;
         if (state_q == NEXT && !last_word) addr_q <= addr_q + 1'b1;
         if (state_q == WAIT) begin
            shreg_q <= bus.rdata;
            cnt_q   <= '0;
         end
         if (fire) begin
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + 1'b1;
         end
      end
   end
   assign bus.re        = re_q;
   assign bus.raddr     = re_q ? addr_q : '0;
   assign bus.ser_valid = fire;
   assign bus.ser_out   = fire & shreg_q[DATA_W-1];
   assign bus.ser_first = fire && cnt_q == '0;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed table and sequence checks for result_reader (N_WORDS 2 and 8).
module tb_result_reader;
   logic clk = 1'b0;
   logic rst, start, tx;
   logic busy_a, done_a, busy_b, done_b;
   logic [31:0] mem [8];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   result_reader_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
   result_reader_if #(.DATA_W(32), .ADDR_W(3)) ifb ();
   result_reader #(.DATA_W(32), .ADDR_W(3), .N_WORDS(2)) dut_a (
      .clk(clk), .rst(rst), .start(start), .bus(ifa.master), .busy(busy_a), .done(done_a));
   result_reader #(.DATA_W(32), .ADDR_W(3), .N_WORDS(8)) dut_b (
      .clk(clk), .rst(rst), .start(start), .bus(ifb.master), .busy(busy_b), .done(done_b));
   always #5 clk = ~clk;
   assign ifa.tx_ready = tx;
   assign ifb.tx_ready = tx;
   always @(posedge clk) begin
      ifa.rdata <= mem[ifa.raddr];
      ifb.rdata <= mem[ifb.raddr];
   end
   logic [8:0] outs_b;
   assign outs_b = {ifb.re, ifb.raddr, ifb.ser_valid, ifb.ser_out, ifb.ser_first, busy_b, done_b};
   logic         mon_en;
   int           nbits [2], nre [2], ndone [2], re_cyc [2], done_cyc [2], viol [2];
   logic [511:0] stream [2], firsts [2];
   logic [23:0]  addrs [2];
   logic         busy_at_done [2], busy_after [2], dn_prev [2];
   task automatic mon(input int k, input logic re, input logic [2:0] ra,
                      input logic sv, input logic so, input logic sf, input logic bz, input logic dn);
      if (!mon_en) return;
      if ((!sv && so) || (!re && ra != 3'd0) || (sf && !sv)) viol[k]++;
      if (re) begin
         if (nre[k] == 0) re_cyc[k] = cyc;
         nre[k]++;
         addrs[k] = {addrs[k][20:0], ra};
      end
      if (sv) begin
         stream[k] = {stream[k][510:0], so};
         firsts[k] = {firsts[k][510:0], sf};
         nbits[k]++;
      end
      if (dn_prev[k]) busy_after[k] = bz;
      dn_prev[k] = dn;
      if (dn) begin
         ndone[k]++;
         done_cyc[k] = cyc;
         busy_at_done[k] = bz;
      end
   endtask
   always @(negedge clk) begin
      cyc++;
      mon(0, ifa.re, ifa.raddr, ifa.ser_valid, ifa.ser_out, ifa.ser_first, busy_a, done_a);
      mon(1, ifb.re, ifb.raddr, ifb.ser_valid, ifb.ser_out, ifb.ser_first, busy_b, done_b);
   end
   task automatic clear();
      for (int k = 0; k < 2; k++) begin
         nbits[k] = 0; nre[k] = 0; ndone[k] = 0; re_cyc[k] = 0; done_cyc[k] = 0; viol[k] = 0;
         stream[k] = '0; firsts[k] = '0; addrs[k] = '0;
         busy_at_done[k] = 1'b0; busy_after[k] = 1'b1; dn_prev[k] = 1'b0;
      end
   endtask
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1; start = 1'b0; tx = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask
   function automatic logic [8:0] e(input logic re, input logic [2:0] ra, input logic sv,
                                    input logic so, input logic sf, input logic bz, input logic dn);
      return {re, ra, sv, so, sf, bz, dn};
   endfunction
   typedef struct {
      logic       st;
      logic       tx;
      logic [8:0] exp;
   } vec_t;
   vec_t tbl [13];
   logic [31:0] w;
   int stall_bad, early;
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0]  = '{1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{1'b1, 1'b1, e(0, 0, 0, 0, 0, 0, 0)};
      tbl[2]  = '{1'b1, 1'b1, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[3]  = '{1'b0, 1'b1, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[4]  = '{1'b0, 1'b1, e(1, 0, 0, 0, 0, 1, 0)};
      tbl[5]  = '{1'b0, 1'b1, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[6]  = '{1'b0, 1'b0, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[7]  = '{1'b0, 1'b0, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[8]  = '{1'b0, 1'b0, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[9]  = '{1'b0, 1'b1, e(0, 0, 1, 1, 1, 1, 0)};
      tbl[10] = '{1'b0, 1'b1, e(0, 0, 1, 1, 0, 1, 0)};
      tbl[11] = '{1'b0, 1'b0, e(0, 0, 0, 0, 0, 1, 0)};
      tbl[12] = '{1'b0, 1'b1, e(0, 0, 1, 0, 0, 1, 0)};
      mon_en = 1'b0;
      clear();
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      mem[0] = 32'hC000_0000;
      rst = 1'b1; start = 1'b0; tx = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("reset_outs", 64'(outs_b), 64'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         start = tbl[i].st;
         tx = tbl[i].tx;
         @(negedge clk);
         chk($sformatf("table_row%0d", i), 64'(outs_b), 64'(tbl[i].exp));
         tick();
      end
      // two-word run, 3-cycle start pulse, latency to done
      mem[0] = 32'h8000_0001; mem[1] = 32'h0;
      do_reset(); clear(); mon_en = 1'b1;
      start = 1'b1; tick(); tick(); tick(); start = 1'b0;
      for (int i = 0; i < 200 && ndone[0] == 0; i++) tick();
      chk("s1_done_cnt", 64'(ndone[0]), 64'd1);
      chk("s1_nbits", 64'(nbits[0]), 64'd64);
      chk("s1_stream", stream[0][63:0], 64'h8000_0001_0000_0000);
      chk("s1_firsts", firsts[0][63:0], 64'h8000_0000_8000_0000);
      chk("s1_latency", 64'(done_cyc[0] - re_cyc[0]), 64'd70);
      chk("s1_viol", 64'(viol[0]), 64'd0);
      // stall of 5 cycles after bit 4
      mem[0] = 32'hA5A5_A5A5;
      do_reset(); clear();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 100 && nbits[1] != 5; i++) tick();
      chk("s2_reach5", 64'(nbits[1]), 64'd5);
      stall_bad = 0;
      tx = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ifb.ser_valid) stall_bad++;
         tick();
      end
      tx = 1'b1;
      chk("s2_stall_valid", 64'(stall_bad), 64'd0);
      chk("s2_hold_cnt", 64'(nbits[1]), 64'd5);
      for (int i = 0; i < 100 && nbits[1] < 32; i++) tick();
      chk("s2_stream", 64'(stream[1][31:0]), 64'hA5A5_A5A5);
      chk("s2_firsts", 64'(firsts[1][31:0]), 64'h8000_0000);
      // full eight-word run
      for (int i = 0; i < 8; i++) mem[i] = 32'(i);
      do_reset(); clear();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 400 && ndone[1] == 0; i++) tick();
      repeat (10) tick();
      chk("s3_nre", 64'(nre[1]), 64'd8);
      chk("s3_addrs", 64'(addrs[1]), 64'o01234567);
      chk("s3_done_cnt", 64'(ndone[1]), 64'd1);
      chk("s3_busy_at_done", 64'(busy_at_done[1]), 64'd1);
      chk("s3_busy_after", 64'(busy_after[1]), 64'd0);
      chk("s3_nbits", 64'(nbits[1]), 64'd256);
      for (int k = 0; k < 8; k++) begin
         w = stream[1][255-32*k -: 32];
         chk($sformatf("s3_word%0d", k), 64'(w), 64'(mem[k]));
      end
      chk("s3_a_nre", 64'(nre[0]), 64'd2);
      chk("s3_viol", 64'(viol[1]), 64'd0);
      // reset during bit 17 of word 3
      for (int i = 0; i < 8; i++) mem[i] = 32'hFFFF_FFFF;
      do_reset(); clear();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 300 && nbits[1] != 113; i++) tick();
      chk("s4_reach_bit17", 64'(nbits[1]), 64'd113);
      rst = 1'b1;
      @(negedge clk);
      chk("s4_active", 64'({ifb.ser_valid, ifb.ser_out}), 64'd3);
      tick();
      @(negedge clk);
      chk("s4_in_reset", 64'(outs_b), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("s4_after_reset", 64'(outs_b), 64'd0);
      tick();
      clear();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 50 && nre[1] < 2; i++) tick();
      chk("s4_restart_addrs", 64'(addrs[1][5:0]), 64'o01);
      // long start, then start during SEND
      for (int i = 0; i < 8; i++) mem[i] = 32'h9E37_79B9 * 32'(i + 1);
      do_reset(); clear();
      early = 0;
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ifb.re) early++;
         tick();
      end
      start = 1'b0;
      @(negedge clk);
      chk("s5_re_at_fall", 64'(ifb.re), 64'd0);
      tick();
      @(negedge clk);
      chk("s5_re_after_fall", 64'({ifb.re, ifb.raddr}), 64'h8);
      chk("s5_early_re", 64'(early), 64'd0);
      for (int i = 0; i < 100 && nbits[1] != 3; i++) tick();
      start = 1'b1;
      repeat (5) tick();
      start = 1'b0;
      for (int i = 0; i < 400 && ndone[1] == 0; i++) tick();
      chk("s5_addrs", 64'(addrs[1]), 64'o01234567);
      chk("s5_nbits", 64'(nbits[1]), 64'd256);
      for (int k = 0; k < 8; k++) begin
         w = stream[1][255-32*k -: 32];
         chk($sformatf("s5_word%0d", k), 64'(w), 64'(mem[k]));
      end
      chk("s5_viol", 64'(viol[1] + viol[0]), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter DATA_W, default 32: width of one product word in result memory.
REQ-002 Parameter ADDR_W, default 3: result-memory address width.
REQ-003 Parameter N_WORDS, default 8: words read per run, range 1..2^ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level request; run begins after start falls.
REQ-007 rdata  input  DATA_W  result-memory read data, valid the cycle after re.
REQ-008 tx_ready  input  1  downstream accepts one bit this cycle.
REQ-009 re  output  1  result-memory read enable.
REQ-010 raddr  output  ADDR_W  result-memory read address.
REQ-011 ser_out  output  1  serial data bit, MSB first.
REQ-012 ser_valid  output  1  ser_out is valid and is consumed this cycle.
REQ-013 ser_first  output  1  marks the first (MSB) bit of a word; only with ser_valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last bit of the last word.

Function
REQ-016 States SHALL be IDLE, ARM, READ, WAIT, SEND, NEXT, DONE.
REQ-017 IDLE->ARM when start=1; else stay in IDLE.
REQ-018 ARM stays while start=1; ARM->READ when start=0; ARM clears addr counter to 0.
REQ-019 READ: re=1, raddr=addr for exactly one cycle; READ->WAIT.
REQ-020 WAIT: re=0; shift register loads rdata at the end of the cycle; bit counter cleared; WAIT->SEND.
REQ-021 SEND, tx_ready=1: ser_valid=1; ser_out=shreg[DATA_W-1]; shreg shifts left one bit, zero fill; bit counter increments.
REQ-022 SEND, tx_ready=0: ser_valid=0; shreg and bit counter hold; stall length unbounded.
REQ-023 ser_first=1 iff in SEND, ser_valid=1 and bit counter=0.
REQ-024 SEND->NEXT on the cycle the bit with counter=DATA_W-1 is accepted.
REQ-025 NEXT: if addr=N_WORDS-1 go to DONE; else addr increments by 1 and go to READ.
REQ-026 DONE: done=1 for one cycle; DONE->IDLE unconditionally.
REQ-027 With tx_ready held high, per-word cost SHALL be DATA_W+3 cycles (READ, WAIT, DATA_W SEND cycles, NEXT).
REQ-028 ser_out SHALL be 0 whenever ser_valid=0; raddr SHALL be 0 whenever re=0.
REQ-029 start is ignored in all states except IDLE and ARM; start high in DONE does not re-arm until IDLE.
REQ-030 addr SHALL never exceed N_WORDS-1; no wrap-around inside a run.
REQ-031 Bit counter width SHALL be ceil(log2(DATA_W))+1.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, addr=0, bit counter=0, shreg=0, from any state including mid-word.
REQ-033 While in reset and the cycle after: re, raddr, ser_out, ser_valid, ser_first, busy and done SHALL all be 0.
REQ-034 A run interrupted by reset is discarded; the next run restarts at address 0.

Verification
REQ-035 Memory {0x80000001, 0x00000000, ...} with N_WORDS=2, start pulsed 3 cycles, tx_ready=1 -> serial bits 1,0x30,1 then 32 zeros; ser_first on bit 0 of each word; done exactly 2*35 cycles after READ is first entered.
REQ-036 Word 0xA5A5A5A5 with tx_ready low for 5 cycles after bit 4 -> ser_valid low 5 cycles; remaining bits continue with no loss or duplication; stream equals 0xA5A5A5A5 MSB first.
REQ-037 Default N_WORDS=8, addresses hold 0..7 -> re pulses exactly 8 times, raddr 0..7 in order; done pulses once; busy falls with done.
REQ-038 rst asserted during bit 17 of word 3 -> next cycle all outputs 0; new start run begins at raddr=0.
REQ-039 start held high for 10 cycles -> no re until the cycle after start falls; start re-asserted during SEND -> no effect on stream or addr.
REQ-040 tx_ready=0 at SEND entry for 3 cycles -> ser_first appears with the first accepted bit, not before.
